pipe_addsub: RTL
================

// Module: pipe_addsub
// PURPOSE
//  Parametrised, pipelined WIDTH-bit adder/subtractor for the CPU datapath; successor to the
//  1-bit full-adder cell. Splits operands into STAGES chunks, resolving one chunk per cycle
//  with the carry registered between stages. Valid/ready on both sides, with per-stage
//  bubble collapsing. Produces carry, signed overflow and zero flags for ALU/branch use.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of chunks; CW = WIDTH/STAGES bits per chunk (CW >= 1)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a/b/sub valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b   1: a-b (a + ~b + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result this cycle
//  sum        out  WIDTH  result, mod 2^WIDTH
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow, i.e. a >= b unsigned)
//  overflow   out  1      signed overflow: sign(A') == sign(B') != sign(sum), where A' = a, B' = b or ~b
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (rst_n low, async): all stage valid bits 0; all data/flag registers 0. Hence
//    out_valid=0, sum=0, cout=0, overflow=0, zero=0. in_ready=1 from the first edge after release.
//  - Stage k (k=0..STAGES-1) holds: valid v[k], partial sum bits [(k+1)*CW-1:0], registered carry,
//    and the untouched upper operand bits (B already inverted if sub) plus the sign bits for overflow.
//  - Stage 0 loads from inputs: chunk0 = a[CW-1:0] + b'[CW-1:0] + sub.
//    Stage k loads from stage k-1: chunk k = A'[k] + B'[k] + carry(k-1).
//  - Load rule: ld[k] = v_src[k] && (!v[k] || adv[k]), where
//      adv[k] = ld[k+1] (stage k drains into k+1), adv[STAGES-1] = out_ready,
//      v_src[0] = in_valid, v_src[k] = v[k-1].
//    On a clock edge: if ld[k], v[k] <= 1 and data captured; else if adv[k], v[k] <= 0.
//    Bubbles collapse: an empty stage accepts regardless of downstream state.
//  - in_ready = !v[0] || adv[0]; combinational from out_ready through the stage chain (no register).
//  - Handshake: transfer on in_valid && in_ready, and on out_valid && out_ready.
//    in_valid may drop without a transfer. Outputs stay stable while out_valid && !out_ready.
//  - Latency: STAGES cycles from input transfer to out_valid with no stalls.
//    Throughput: 1 op/cycle with out_ready held high.
//  - out_valid = v[STAGES-1]; sum/cout/overflow/zero come directly from the last-stage registers.
//    zero is computed from the full sum in the last stage.
//  - Ordering: results leave in acceptance order; no reorder, no drop, no duplication.
//  - Simultaneous accept and drain on a full pipe: allowed; occupancy is unchanged.
//  - Wrap-around: sum is modulo 2^WIDTH; carries beyond the MSB appear only on cout.
//  - Reset mid-operation: all in-flight operations are discarded; nothing is emitted after release.
//  - STAGES=1: a single registered full-width add, latency 1.
//  - Width check: elaboration fails if WIDTH % STAGES != 0.
// TESTING (WIDTH=32, STAGES=4 unless noted)
//  1. a=32'h0000_0005, b=32'h0000_0003, sub=0, out_ready=1 -> 4 cycles later sum=8, cout=0,
//     overflow=0, zero=0.
//  2. Carry chain: a=32'hFFFF_FFFF, b=1, sub=0 -> sum=0, cout=1, zero=1, overflow=0.
//     Then a=32'h7FFF_FFFF, b=1 -> sum=32'h8000_0000, overflow=1, cout=0.
//  3. Subtract: a=3, b=5, sub=1 -> sum=32'hFFFF_FFFE, cout=0 (borrow), overflow=0.
//     Then a=5, b=5, sub=1 -> sum=0, zero=1, cout=1.
//  4. Back-to-back: 8 ops on consecutive cycles, out_ready=1 -> 8 results on 8 consecutive
//     cycles starting cycle 4, in order; in_ready held 1 throughout.
//  5. Backpressure: stream 6 ops, out_ready=0 from cycle 5 for 3 cycles -> in_ready goes 0 once
//     4 ops are held; out_valid=1 with sum stable; no loss or reorder after out_ready returns to 1.
//     Then a single op with an empty pipe stalls at the output while an upstream bubble collapses.
//  6. Reset: assert rst_n=0 with 3 ops in flight -> outputs go to 0 immediately (async);
//     after release, no stale out_valid; STAGES=1 and WIDTH=8 builds also run scenarios 1-3.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. Operands are resolved one CW-bit chunk per stage,
// with the chunk carry registered between stages and a valid/ready handshake at both ends.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;

  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_chk
    $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] v, ld, adv;
  logic [STAGES:0]   vsrc;

  assign vsrc = {v, in_valid};

  // Stall propagates back from the output; an empty stage loads regardless of downstream.
  always_comb begin
    logic nxt;
    ld  = '0;
    adv = '0;
    nxt = out_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      adv[k] = nxt;
      ld[k]  = vsrc[k] && (!v[k] || nxt);
      nxt    = ld[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k])       v[k] <= 1'b1;
        else if (adv[k]) v[k] <= 1'b0;
      end
    end
  end

  // Stage k sees only the operand bits not yet consumed (RW wide), so the
  // operand registers shrink by CW per stage while the partial sum grows.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k*CW;
    logic [RW-1:0]         sa, sb;
    logic                  sc;
    logic [CW:0]           ch;
    logic [(k+1)*CW-1:0]   ns, s_q;
    logic                  c_q;

    if (k == 0) begin : g_src
      assign sa = a;
      assign sb = b ^ {WIDTH{sub}};
      assign sc = sub;
      assign ns = ch[CW-1:0];
    end else begin : g_src
      assign sa = g_st[k-1].g_fwd.a_q;
      assign sb = g_st[k-1].g_fwd.b_q;
      assign sc = g_st[k-1].c_q;
      assign ns = {ch[CW-1:0], g_st[k-1].s_q};
    end

    assign ch = {1'b0, sa[CW-1:0]} + {1'b0, sb[CW-1:0]} + (CW+1)'(sc);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (ld[k]) begin
        s_q <= ns;
        c_q <= ch[CW];
      end
    end

    if (k < STAGES-1) begin : g_fwd
      logic [RW-CW-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[k]) begin
          a_q <= sa[RW-1:CW];
          b_q <= sb[RW-1:CW];
        end
      end
    end else begin : g_last
      logic ovf_q, zero_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (ld[k]) begin
          ovf_q  <= (sa[CW-1] == sb[CW-1]) && (ch[CW-1] != sa[CW-1]);
          zero_q <= (ns == '0);
        end
      end
    end
  end

  assign in_ready  = !v[0] || adv[0];
  assign out_valid = vsrc[STAGES];
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign overflow  = g_st[STAGES-1].g_last.ovf_q;
  assign zero      = g_st[STAGES-1].g_last.zero_q;

endmodule
